// File: rtl/traffic_lamp_sequencer.sv
// Lamp sequencer behind the two-way traffic controller: timed yellow, all-red clearance, minimum green.
// Optional flashing-yellow fault mode is compiled in with `define TRAFFIC_FLASH_EN.
module traffic_lamp_sequencer #(
  parameter int unsigned MIN_GRN_CYCLES = 4,
  parameter int unsigned YEL_CYCLES     = 3,
  parameter int unsigned ALLRED_CYCLES  = 2,
  parameter int unsigned CNT_W          = 4
`ifdef TRAFFIC_FLASH_EN
  ,
  parameter int unsigned FLASH_HALF     = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_go,
  input  logic       ns_go,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash,
`endif
  output logic       ew_red,
  output logic       ew_yel,
  output logic       ew_grn,
  output logic       ns_red,
  output logic       ns_yel,
  output logic       ns_grn,
  output logic [2:0] phase
);

  localparam logic [2:0] ALL_RED = 3'd0;
  localparam logic [2:0] EW_GRN  = 3'd1;
  localparam logic [2:0] EW_YEL  = 3'd2;
  localparam logic [2:0] NS_GRN  = 3'd3;
  localparam logic [2:0] NS_YEL  = 3'd4;
  localparam logic [2:0] FLASH   = 3'd5;

  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GR_LAST = CNT_W'(MIN_GRN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YL_LAST = CNT_W'(YEL_CYCLES - 1);
`ifdef TRAFFIC_FLASH_EN
  localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FLASH_HALF - 1);
`endif

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             last_ns, last_ns_nx;
  logic             blink, blink_nx;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer + CNT_W'(1);
    last_ns_nx = last_ns;
    blink_nx   = blink;
    case (state)
      ALL_RED: begin
        if (timer == AR_LAST) begin
          timer_nx = timer;
          // Both requesting: serve the direction that did not have the last green.
          if (ew_go && (!ns_go || last_ns)) state_nx = EW_GRN;
          else if (ns_go)                   state_nx = NS_GRN;
        end
      end
      EW_GRN: begin
        if (timer >= GR_LAST) begin
          timer_nx = timer;
          if (!ew_go) state_nx = EW_YEL;
        end
      end
      NS_GRN: begin
        if (timer >= GR_LAST) begin
          timer_nx = timer;
          if (!ns_go) state_nx = NS_YEL;
        end
      end
      EW_YEL: if (timer == YL_LAST) state_nx = ALL_RED;
      NS_YEL: if (timer == YL_LAST) state_nx = ALL_RED;
`ifdef TRAFFIC_FLASH_EN
      FLASH: begin
        if (!flash) begin
          state_nx = ALL_RED;
        end else if (timer == FH_LAST) begin
          timer_nx = '0;
          blink_nx = !blink;
        end
      end
`endif
      default: state_nx = ALL_RED;
    endcase
`ifdef TRAFFIC_FLASH_EN
    if (flash && state != FLASH) begin
      state_nx = FLASH;
      blink_nx = 1'b1;
    end
`endif
    if (state_nx != state) timer_nx = '0;
    if (state_nx == EW_GRN && state != EW_GRN) last_ns_nx = 1'b0;
    if (state_nx == NS_GRN && state != NS_GRN) last_ns_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ALL_RED;
      timer   <= '0;
      last_ns <= 1'b1;
      blink   <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      last_ns <= last_ns_nx;
      blink   <= blink_nx;
    end
  end

  // Lamps depend on registered state only; illegal codes show all red.
  always_comb begin
    ew_red = 1'b1; ew_yel = 1'b0; ew_grn = 1'b0;
    ns_red = 1'b1; ns_yel = 1'b0; ns_grn = 1'b0;
    case (state)
      EW_GRN: begin ew_red = 1'b0; ew_grn = 1'b1; end
      EW_YEL: begin ew_red = 1'b0; ew_yel = 1'b1; end
      NS_GRN: begin ns_red = 1'b0; ns_grn = 1'b1; end
      NS_YEL: begin ns_red = 1'b0; ns_yel = 1'b1; end
`ifdef TRAFFIC_FLASH_EN
      FLASH: begin
        ew_red = 1'b0; ns_red = 1'b0;
        ew_yel = blink; ns_yel = blink;
      end
`endif
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_lamp_sequencer.sv
// Scoreboard bench for traffic_lamp_sequencer: a countdown reference model queues expected
// phase/lamps per driven cycle; directed sequences add duration and alternation checks.
module tb_traffic_lamp_sequencer;

  localparam int MIN_G  = 4;
  localparam int YEL    = 3;
  localparam int ALLRED = 2;
  localparam int FH     = 2;

  logic       clk = 1'b0;
  logic       reset, ew_go, ns_go, flash;
  logic       ew_red, ew_yel, ew_grn, ns_red, ns_yel, ns_grn;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] sb[$];

  int m_ph, m_left;
  bit m_last_ns, m_blink;

  traffic_lamp_sequencer #(
    .MIN_GRN_CYCLES(MIN_G),
    .YEL_CYCLES    (YEL),
    .ALLRED_CYCLES (ALLRED),
    .CNT_W         (4)
`ifdef TRAFFIC_FLASH_EN
    ,
    .FLASH_HALF    (FH)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ew_go (ew_go),
    .ns_go (ns_go),
`ifdef TRAFFIC_FLASH_EN
    .flash (flash),
`endif
    .ew_red(ew_red),
    .ew_yel(ew_yel),
    .ew_grn(ew_grn),
    .ns_red(ns_red),
    .ns_yel(ns_yel),
    .ns_grn(ns_grn),
    .phase (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] lamps_of(input int ph, input bit bl);
    case (ph)
      0: return 6'b100_100;
      1: return 6'b001_100;
      2: return 6'b010_100;
      3: return 6'b100_001;
      4: return 6'b100_010;
      5: return bl ? 6'b010_010 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  // Countdown model: m_left is the number of further edges before the phase may move on.
  task automatic model_step(input bit e, input bit n, input bit r, input bit f);
    if (r) begin
      m_ph = 0; m_left = ALLRED - 1; m_last_ns = 1'b1; m_blink = 1'b0;
    end
`ifdef TRAFFIC_FLASH_EN
    else if (f && m_ph != 5) begin
      m_ph = 5; m_left = FH - 1; m_blink = 1'b1;
    end
`endif
    else begin
      case (m_ph)
        0: if (m_left > 0) m_left--;
           else if (e || n) begin
             if (e && !(n && !m_last_ns)) begin m_ph = 1; m_last_ns = 1'b0; end
             else begin m_ph = 3; m_last_ns = 1'b1; end
             m_left = MIN_G - 1;
           end
        1: if (m_left > 0) m_left--; else if (!e) begin m_ph = 2; m_left = YEL - 1; end
        3: if (m_left > 0) m_left--; else if (!n) begin m_ph = 4; m_left = YEL - 1; end
        2, 4: if (m_left > 0) m_left--; else begin m_ph = 0; m_left = ALLRED - 1; end
        5: if (!f) begin m_ph = 0; m_left = ALLRED - 1; end
           else if (m_left > 0) m_left--;
           else begin m_left = FH - 1; m_blink = !m_blink; end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic step(input bit e, input bit n, input bit r, input bit f);
    logic [8:0] exp;
    logic [5:0] obs;
    bit         safe;
    @(negedge clk);
    ew_go = e; ns_go = n; reset = r; flash = f;
    model_step(e, n, r, f);
    sb.push_back({3'(m_ph), lamps_of(m_ph, m_blink)});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    obs = {ew_red, ew_yel, ew_grn, ns_red, ns_yel, ns_grn};
    check("phase", 32'(phase), 32'(exp[8:6]));
    check("lamps", 32'(obs), 32'(exp[5:0]));
    if (phase != 3'd5) begin
      safe = ($countones(obs[5:3]) == 1) && ($countones(obs[2:0]) == 1)
             && (ew_red || ns_red);
      check("safety", 32'(safe), 32'd1);
    end
  endtask

  initial begin
    int g, y, r, prev_dir, dir, served;
    bit seen;
    reset = 1'b1; ew_go = 1'b0; ns_go = 1'b0; flash = 1'b0;

    // 1: reset with ew_go held, then two all-red edges before EW green
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_reds", 32'({ew_red, ns_red}), 32'b11);
    step(1, 0, 0, 0);
    check("t1_red1", 32'(ew_red && ns_red), 32'd1);
    step(1, 0, 0, 0);
    check("t1_grn", 32'(ew_grn), 32'd1);

    // 2: long EW green, then hand over to NS
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    y = 0; r = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 1, 0, 0);
      if (ew_yel) y++;
      else if (ew_red && ns_red) r++;
      if (ns_grn) seen = 1'b1;
    end
    check("t2_ns_grn_reached", 32'(seen), 32'd1);
    check("t2_yel_len", 32'(y), 32'd3);
    check("t2_allred_len", 32'(r), 32'd2);

    // 3: single-cycle EW request gets the minimum green
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    g = ew_grn ? 1 : 0; y = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0);
      if (ew_grn) g++;
      if (ew_yel) y++;
    end
    check("t3_grn_len", 32'(g), 32'd4);
    check("t3_yel_len", 32'(y), 32'd3);
    check("t3_rests_red", 32'(phase), 32'd0);

    // 4: contending requests are served in alternation
    prev_dir = -1; served = 0;
    for (int k = 0; k < 4; k++) begin
      dir = -1;
      for (int i = 0; i < 10 && dir < 0; i++) begin
        step(1, 1, 0, 0);
        if (ew_grn) dir = 0;
        else if (ns_grn) dir = 1;
      end
      check("t4_served", 32'(dir >= 0), 32'd1);
      if (prev_dir >= 0 && dir >= 0) check("t4_alternate", 32'(dir), 32'(1 - prev_dir));
      if (dir >= 0) begin prev_dir = dir; served++; end
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
    end
    check("t4_served_cnt", 32'(served), 32'd4);

    // 5: reset during second cycle of NS yellow
    step(0, 1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0, 0, 0, 0);
      if (ns_yel) seen = 1'b1;
    end
    check("t5_ns_yel_reached", 32'(seen), 32'd1);
    step(0, 0, 0, 0);
    check("t5_yel2", 32'(ns_yel), 32'd1);
    step(0, 0, 1, 0);
    check("t5_rst_phase", 32'(phase), 32'd0);
    check("t5_rst_reds", 32'({ew_red, ew_yel, ns_red, ns_yel}), 32'b1010);
    step(1, 0, 0, 0);
    check("t5_clear_full", 32'(phase), 32'd0);
    step(1, 0, 0, 0);
    check("t5_grn", 32'(phase), 32'd1);

`ifdef TRAFFIC_FLASH_EN
    // 6: flash from EW green blinks 2 on / 2 off, then full clearance
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 1);
      check("t6_blink", 32'({ew_yel, ns_yel}), ((i % 4) < 2) ? 32'b11 : 32'b00);
      check("t6_dark", 32'({ew_red, ew_grn, ns_red, ns_grn}), 32'd0);
    end
    step(1, 0, 0, 0);
    check("t6_exit_red", 32'(phase), 32'd0);
    step(1, 0, 0, 0);
    check("t6_exit_red2", 32'(phase), 32'd0);
    step(1, 0, 0, 0);
    check("t6_grn", 32'(ew_grn), 32'd1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    check("t6_rst_over_flash", 32'(phase), 32'd0);
`endif

    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
